// File: rtl/tdm_pkg.sv
// Shared constants and types for the 6-channel TDM receive path.
package tdm_pkg;

  localparam int TDM_NUM_CH = 6;
  localparam int TDM_SEL_W  = 3;

  typedef logic [TDM_SEL_W-1:0]  tdm_sel_t;
  typedef logic [TDM_NUM_CH-1:0] tdm_word_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N slot counter; a sync forces the count to 1 because the sync cycle itself is slot 0.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N     = TDM_NUM_CH,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load1,
  output logic [SEL_W-1:0] S,
  output logic             last
);

  localparam logic [SEL_W-1:0] LAST_S = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] ZERO_S = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] ONE_S  = {{(SEL_W-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0] r_s;

  // Slot register: reset > sync reload > wrap at N-1 > increment > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= ZERO_S;
    end else if (en && load1) begin
      r_s <= ONE_S;
    end else if (en && (r_s == LAST_S)) begin
      r_s <= ZERO_S;
    end else if (en) begin
      r_s <= r_s + ONE_S;
    end else begin
      r_s <= r_s;
    end
  end

  assign S    = r_s;
  assign last = (r_s == LAST_S);

endmodule

// File: rtl/tdm_demux_6ch.sv
// TDM receiver: rebuilds an N-bit parallel word from one serial bit per enabled slot
// and drives the slot select back to the sending mux.
module tdm_demux_6ch
  import tdm_pkg::*;
#(
  parameter int N     = TDM_NUM_CH,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [SEL_W-1:0] S,
  output logic [N-1:0]     Q,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam logic [SEL_W-1:0] ZERO_S = {SEL_W{1'b0}};

  logic [SEL_W-1:0] w_s;
  logic             w_last;
  logic [N-1:0]     w_sh_next;
  logic [N-1:0]     r_sh;
  logic [N-1:0]     r_q;
  logic             r_frame_valid;
  logic             r_sync_err;

  tdm_slot_counter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load1 (sync),
    .S     (w_s),
    .last  (w_last)
  );

  // Shadow word with the current slot's bit replaced by din.
  always_comb begin
    w_sh_next = r_sh;
    for (int k = 0; k < N; k++) begin
      if (w_s == SEL_W'(k)) begin
        w_sh_next[k] = din;
      end else begin
        w_sh_next[k] = r_sh[k];
      end
    end
  end

  // Shadow, output word and pulse flags; a sync always wins over frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh          <= {N{1'b0}};
      r_q           <= {N{1'b0}};
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else if (!en) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else if (sync) begin
      r_sh          <= {{(N-1){1'b0}}, din};
      r_frame_valid <= 1'b0;
      r_sync_err    <= (w_s != ZERO_S);
    end else if (w_last) begin
      r_q           <= {din, r_sh[N-2:0]};
      r_sh          <= {N{1'b0}};
      r_frame_valid <= 1'b1;
      r_sync_err    <= 1'b0;
    end else begin
      r_sh          <= w_sh_next;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end
  end

  assign S           = w_s;
  assign Q           = r_q;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_6ch.sv
// Self-checking bench for tdm_demux_6ch: vector table through a scoreboard queue,
// then a back-to-back frame sequence with random data.
module tb_tdm_demux_6ch;
  import tdm_pkg::*;

  logic      clk;
  logic      rst;
  logic      en;
  logic      din;
  logic      sync;
  tdm_sel_t  s;
  tdm_word_t q;
  logic      frame_valid;
  logic      sync_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic      rst;
    logic      en;
    logic      sync;
    logic      din;
    tdm_sel_t  s;
    tdm_word_t q;
    logic      fv;
    logic      se;
  } vec_t;

  typedef struct {
    tdm_sel_t  s;
    tdm_word_t q;
    logic      fv;
    logic      se;
  } exp_t;

  vec_t      vecs[$];
  exp_t      sb[$];
  tdm_word_t wq[$];

  tdm_demux_6ch dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .S           (s),
    .Q           (q),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic sy, input logic d,
                              input int es, input int eq, input logic efv, input logic ese);
    vec_t v;
    v.rst = r; v.en = e; v.sync = sy; v.din = d;
    v.s = tdm_sel_t'(es); v.q = tdm_word_t'(eq); v.fv = efv; v.se = ese;
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t      e;
    tdm_word_t w;
    rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;

    // reset then idle
    add(1,0,0,0, 0,'h00,0,0); add(1,0,0,0, 0,'h00,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 0,'h00,0,0);
    // single frame 1,1,1,1,0,0
    add(0,1,1,1, 1,'h00,0,0); add(0,1,0,1, 2,'h00,0,0); add(0,1,0,1, 3,'h00,0,0);
    add(0,1,0,1, 4,'h00,0,0); add(0,1,0,0, 5,'h00,0,0); add(0,1,0,0, 0,'h0F,1,0);
    add(0,0,0,0, 0,'h0F,0,0);
    // gapped enable between slots 2 and 3
    add(0,1,1,1, 1,'h0F,0,0); add(0,1,0,1, 2,'h0F,0,0); add(0,1,0,1, 3,'h0F,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 3,'h0F,0,0);
    add(0,1,0,1, 4,'h0F,0,0); add(0,1,0,0, 5,'h0F,0,0); add(0,1,0,0, 0,'h0F,1,0);
    add(0,0,0,0, 0,'h0F,0,0);
    // mid-frame sync after slots 0..3
    add(0,1,1,1, 1,'h0F,0,0); add(0,1,0,0, 2,'h0F,0,0); add(0,1,0,1, 3,'h0F,0,0);
    add(0,1,0,0, 4,'h0F,0,0); add(0,1,1,1, 1,'h0F,0,1); add(0,1,0,0, 2,'h0F,0,0);
    add(0,1,0,1, 3,'h0F,0,0); add(0,1,0,1, 4,'h0F,0,0); add(0,1,0,0, 5,'h0F,0,0);
    add(0,1,0,1, 0,'h2D,1,0);
    // sync at the last slot wins over completion
    add(0,1,1,1, 1,'h2D,0,0); add(0,1,0,0, 2,'h2D,0,0); add(0,1,0,0, 3,'h2D,0,0);
    add(0,1,0,0, 4,'h2D,0,0); add(0,1,0,0, 5,'h2D,0,0); add(0,1,1,0, 1,'h2D,0,1);
    add(0,1,0,1, 2,'h2D,0,0); add(0,1,0,1, 3,'h2D,0,0); add(0,1,0,1, 4,'h2D,0,0);
    add(0,1,0,1, 5,'h2D,0,0); add(0,1,0,1, 0,'h3E,1,0);
    // sync ignored while en=0
    add(0,0,1,1, 0,'h3E,0,0);
    // reset mid-frame at S=4, then frame 0,1,0,1,0,1
    add(0,1,1,1, 1,'h3E,0,0); add(0,1,0,1, 2,'h3E,0,0); add(0,1,0,1, 3,'h3E,0,0);
    add(0,1,0,1, 4,'h3E,0,0); add(1,1,0,1, 0,'h00,0,0);
    add(0,1,0,0, 1,'h00,0,0); add(0,1,0,1, 2,'h00,0,0); add(0,1,0,0, 3,'h00,0,0);
    add(0,1,0,1, 4,'h00,0,0); add(0,1,0,0, 5,'h00,0,0); add(0,1,0,1, 0,'h2A,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync; din = vecs[i].din;
      e.s = vecs[i].s; e.q = vecs[i].q; e.fv = vecs[i].fv; e.se = vecs[i].se;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("S", i, int'(s), int'(e.s));
      chk("Q", i, int'(q), int'(e.q));
      chk("frame_valid", i, int'(frame_valid), int'(e.fv));
      chk("sync_err", i, int'(sync_err), int'(e.se));
    end

    // back-to-back: three frames with en held high
    w = '0;
    for (int c = 0; c < 18; c++) begin
      rst = 1'b0; en = 1'b1; sync = (c == 0); din = 1'($urandom_range(0, 1));
      w[c % 6] = din;
      if ((c % 6) == 5) wq.push_back(w);
      @(posedge clk);
      #1;
      chk("b2b_frame_valid", c, int'(frame_valid), int'((c % 6) == 5));
      chk("b2b_sync_err", c, int'(sync_err), 0);
      if (frame_valid) begin
        if (wq.size() == 0) chk("b2b_unexpected_frame", c, 1, 0);
        else chk("b2b_Q", c, int'(q), int'(wq.pop_front()));
      end
    end
    en = 1'b0; sync = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_pending_frames", 18, wq.size(), 0);
    chk("idle_frame_valid", 19, int'(frame_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
